// File: rtl/axis_read_sched.sv
// axis_read_sched
//   Round-robin read-job scheduler in front of a single axis_read instance.
//   Accepts (start address, length) jobs from NB_REQ requesters. For each
//   granted job it sends the 3-word cfg sequence (id, address, length) to
//   axis_read, then counts qualified stream beats until the job completes.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   req_addr/req_len      per-requester job, slice i = [i*CFG_DWIDTH +: CFG_DWIDTH]
//   req_val / req_rdy     per-requester job handshake (req_rdy only in IDLE)
//   done                  one-cycle completion pulse to the owning requester
//   owner                 one-hot owner of the axis_read stream, 0 when idle
//   cfg_addr/data/valid   cfg bus master towards axis_read
//   strm_valid/ready      monitor of axis_read output handshake
//   busy                  high whenever not IDLE
//   err                   sticky: a stream beat was seen outside STREAM
module axis_read_sched #(
  parameter int NB_REQ     = 4,
  parameter int CFG_ID     = 1,
  parameter int CFG_ADDR   = 23,
  parameter int CFG_DATA   = 24,
  parameter int CFG_AWIDTH = 5,
  parameter int CFG_DWIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NB_REQ*CFG_DWIDTH-1:0] req_addr,
  input  logic [NB_REQ*CFG_DWIDTH-1:0] req_len,
  input  logic [NB_REQ-1:0]            req_val,
  output logic [NB_REQ-1:0]            req_rdy,
  output logic [NB_REQ-1:0]            done,
  output logic [NB_REQ-1:0]            owner,
  output logic [CFG_AWIDTH-1:0]        cfg_addr,
  output logic [CFG_DWIDTH-1:0]        cfg_data,
  output logic                         cfg_valid,
  input  logic                         strm_valid,
  input  logic                         strm_ready,
  output logic                         busy,
  output logic                         err
);

  localparam int PW = (NB_REQ > 1) ? $clog2(NB_REQ) : 1;

  localparam logic [5:0] S_IDLE      = 6'b000001;
  localparam logic [5:0] S_CFG_ID    = 6'b000010;
  localparam logic [5:0] S_CFG_START = 6'b000100;
  localparam logic [5:0] S_CFG_LEN   = 6'b001000;
  localparam logic [5:0] S_STREAM    = 6'b010000;
  localparam logic [5:0] S_DONE      = 6'b100000;

  logic [5:0]            state;
  logic [PW-1:0]         ptr;
  logic [PW-1:0]         grant;
  logic                  grant_any;
  logic                  hs;
  logic                  beat;
  logic [CFG_DWIDTH-1:0] job_addr;
  // Holds the job length through the cfg words, then counts down in STREAM.
  logic [CFG_DWIDTH-1:0] remaining;
  logic [CFG_DWIDTH-1:0] sel_addr;
  logic [CFG_DWIDTH-1:0] sel_len;

  assign beat = strm_valid & strm_ready;
  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE) ? owner : '0;

  // Round-robin search starting at ptr. Walking the offsets downward lets the
  // smallest offset from ptr be the last (winning) assignment.
  always_comb begin
    int idx;
    idx       = 0;
    grant     = ptr;
    grant_any = 1'b0;
    for (int k = NB_REQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NB_REQ;
      if (req_val[idx]) begin
        grant     = PW'(idx);
        grant_any = 1'b1;
      end
    end
  end

  assign hs = (state == S_IDLE) && grant_any && !rst;

  always_comb begin
    req_rdy = '0;
    if (hs) req_rdy[grant] = 1'b1;
  end

  assign sel_addr = req_addr[int'(grant)*CFG_DWIDTH +: CFG_DWIDTH];
  assign sel_len  = req_len[int'(grant)*CFG_DWIDTH +: CFG_DWIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      ptr       <= '0;
      owner     <= '0;
      job_addr  <= '0;
      remaining <= '0;
      cfg_valid <= 1'b0;
      cfg_addr  <= '0;
      cfg_data  <= '0;
      err       <= 1'b0;
    end else begin
      // cfg bus idles at zero; only the three sequence states override it
      cfg_valid <= 1'b0;
      cfg_addr  <= '0;
      cfg_data  <= '0;
      if (beat && state != S_STREAM) err <= 1'b1;

      case (state)
        S_IDLE: begin
          if (hs) begin
            job_addr  <= sel_addr;
            remaining <= sel_len;
            owner     <= req_rdy;
            ptr       <= (int'(grant) == NB_REQ - 1) ? '0 : grant + 1'b1;
            if (sel_len != '0) begin
              state     <= S_CFG_ID;
              cfg_valid <= 1'b1;
              cfg_addr  <= CFG_AWIDTH'(CFG_ADDR);
              cfg_data  <= CFG_DWIDTH'(CFG_ID);
            end else begin
              state <= S_DONE;
            end
          end
        end
        S_CFG_ID: begin
          state     <= S_CFG_START;
          cfg_valid <= 1'b1;
          cfg_addr  <= CFG_AWIDTH'(CFG_DATA);
          cfg_data  <= job_addr;
        end
        S_CFG_START: begin
          state     <= S_CFG_LEN;
          cfg_valid <= 1'b1;
          cfg_addr  <= CFG_AWIDTH'(CFG_DATA);
          cfg_data  <= remaining;
        end
        S_CFG_LEN: begin
          state <= S_STREAM;
        end
        S_STREAM: begin
          if (beat) begin
            remaining <= remaining - 1'b1;
            if (remaining == CFG_DWIDTH'(1)) state <= S_DONE;
          end
        end
        S_DONE: begin
          owner <= '0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_read_sched.sv
module tb_axis_read_sched;
  localparam int NB = 4;
  localparam int AW = 5;
  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [NB*DW-1:0]  req_addr;
  logic [NB*DW-1:0]  req_len;
  logic [NB-1:0]     req_val;
  logic [NB-1:0]     req_rdy;
  logic [NB-1:0]     done;
  logic [NB-1:0]     owner;
  logic [AW-1:0]     cfg_addr;
  logic [DW-1:0]     cfg_data;
  logic              cfg_valid;
  logic              strm_valid;
  logic              strm_ready;
  logic              busy;
  logic              err;

  int checks   = 0;
  int failures = 0;
  bit mon_en   = 1'b0;

  logic [AW+DW-1:0] cfg_q[$];
  logic [NB-1:0]    done_q[$];
  logic [AW+DW-1:0] cfg_e;
  logic [NB-1:0]    done_e;

  axis_read_sched #(
    .NB_REQ(NB), .CFG_ID(1), .CFG_ADDR(23), .CFG_DATA(24),
    .CFG_AWIDTH(AW), .CFG_DWIDTH(DW)
  ) dut (
    .clk(clk), .rst(rst),
    .req_addr(req_addr), .req_len(req_len), .req_val(req_val), .req_rdy(req_rdy),
    .done(done), .owner(owner),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_valid(cfg_valid),
    .strm_valid(strm_valid), .strm_ready(strm_ready),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Scoreboard: cfg words and done pulses are compared in arrival order.
  always @(negedge clk) begin
    if (mon_en) begin
      if (cfg_valid === 1'b1) begin
        checks++;
        if (cfg_q.size() == 0) begin
          failures++;
          $display("FAIL cfg_unexpected got=%0d/%h required=none", cfg_addr, cfg_data);
        end else begin
          cfg_e = cfg_q.pop_front();
          if ({cfg_addr, cfg_data} !== cfg_e) begin
            failures++;
            $display("FAIL cfg_word got=%0d/%h required=%0d/%h",
                     cfg_addr, cfg_data, cfg_e[AW+DW-1:DW], cfg_e[DW-1:0]);
          end
        end
      end else begin
        checks++;
        if (cfg_valid !== 1'b0 || cfg_addr !== '0 || cfg_data !== '0) begin
          failures++;
          $display("FAIL cfg_idle got=%b/%0d/%h required=0/0/0", cfg_valid, cfg_addr, cfg_data);
        end
      end
      if (done !== '0) begin
        checks++;
        if (done_q.size() == 0) begin
          failures++;
          $display("FAIL done_unexpected got=%b required=none", done);
        end else begin
          done_e = done_q.pop_front();
          if (done !== done_e) begin
            failures++;
            $display("FAIL done_vec got=%b required=%b", done, done_e);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_job(input int i, input logic [DW-1:0] a, input logic [DW-1:0] l);
    req_addr[i*DW +: DW] = a;
    req_len[i*DW +: DW]  = l;
  endtask

  task automatic push_cfg(input logic [DW-1:0] a, input logic [DW-1:0] l);
    cfg_q.push_back({5'd23, 32'd1});
    cfg_q.push_back({5'd24, a});
    cfg_q.push_back({5'd24, l});
  endtask

  // Drives n qualified beats; returns #1 into the cycle after the final beat.
  task automatic do_beats(input int n, input bit toggle);
    int got = 0;
    int k   = 0;
    while (got < n && k < 1000) begin
      strm_valid = 1'b1;
      strm_ready = toggle ? (k % 2 == 0) : 1'b1;
      if (strm_ready) got++;
      tick();
      k++;
    end
    strm_valid = 1'b0;
    strm_ready = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    req_val = '0;
    strm_valid = 1'b0;
    strm_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    req_addr = '0; req_len = '0;
    apply_reset();
    @(negedge clk);
    checks++;
    if ({req_rdy, done, owner, cfg_valid, cfg_addr, cfg_data, busy, err} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got rdy=%b done=%b own=%b cv=%b ca=%0d cd=%h busy=%b err=%b required=all 0",
               req_rdy, done, owner, cfg_valid, cfg_addr, cfg_data, busy, err);
    end
    mon_en = 1'b1;
    tick();
  endtask

  task automatic test_single();
    set_job(0, 32'h1000, 32'd8);
    req_val = 4'b0001;
    @(negedge clk);
    checks++;
    if (req_rdy !== 4'b0001) begin failures++; $display("FAIL single_rdy got=%b required=0001", req_rdy); end
    push_cfg(32'h1000, 32'd8);
    done_q.push_back(4'b0001);
    tick();
    req_val = '0;
    @(negedge clk);
    checks++;
    if (owner !== 4'b0001 || busy !== 1'b1) begin
      failures++; $display("FAIL single_owner got=%b/%b required=0001/1", owner, busy);
    end
    tick(); tick(); tick();
    do_beats(8, 1'b0);
    @(negedge clk);
    checks++;
    if (done !== 4'b0001 || owner !== 4'b0001) begin
      failures++; $display("FAIL single_done got=%b/%b required=0001/0001", done, owner);
    end
    tick();
    @(negedge clk);
    checks++;
    if (owner !== '0 || busy !== 1'b0 || err !== 1'b0) begin
      failures++; $display("FAIL single_idle got own=%b busy=%b err=%b required=0/0/0", owner, busy, err);
    end
  endtask

  task automatic test_round_robin();
    int order[4] = '{0, 1, 3, 0};
    apply_reset();
    for (int i = 0; i < NB; i++) set_job(i, 32'h100 * (i + 1), 32'd2);
    req_val = 4'b1011;
    for (int j = 0; j < 4; j++) begin
      int w = 0;
      logic [NB-1:0] exp_oh;
      exp_oh = '0;
      exp_oh[order[j]] = 1'b1;
      @(negedge clk);
      while (req_rdy === '0 && w < 20) begin tick(); @(negedge clk); w++; end
      checks++;
      if (req_rdy !== exp_oh) begin
        failures++; $display("FAIL rr_grant%0d got=%b required=%b", j, req_rdy, exp_oh);
      end
      push_cfg(32'h100 * (order[j] + 1), 32'd2);
      done_q.push_back(exp_oh);
      tick(); tick(); tick(); tick();
      do_beats(2, 1'b0);
      @(negedge clk);
      checks++;
      if (done !== exp_oh) begin
        failures++; $display("FAIL rr_done%0d got=%b required=%b", j, done, exp_oh);
      end
      tick();
    end
    req_val = '0;
    tick();
  endtask

  task automatic test_zero_len();
    set_job(2, 32'hABCD, 32'd0);
    req_val = 4'b0100;
    @(negedge clk);
    checks++;
    if (req_rdy !== 4'b0100) begin failures++; $display("FAIL zero_rdy got=%b required=0100", req_rdy); end
    done_q.push_back(4'b0100);
    tick();
    req_val = '0;
    @(negedge clk);
    checks++;
    if (done !== 4'b0100 || owner !== 4'b0100 || cfg_valid !== 1'b0) begin
      failures++; $display("FAIL zero_done got=%b/%b/%b required=0100/0100/0", done, owner, cfg_valid);
    end
    tick();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || err !== 1'b0 || owner !== '0) begin
      failures++; $display("FAIL zero_idle got busy=%b err=%b own=%b required=0/0/0", busy, err, owner);
    end
  endtask

  task automatic test_backpressure();
    set_job(1, 32'h2000, 32'd5);
    req_val = 4'b0010;
    push_cfg(32'h2000, 32'd5);
    done_q.push_back(4'b0010);
    tick();
    req_val = '0;
    tick(); tick(); tick();
    do_beats(5, 1'b1);
    @(negedge clk);
    checks++;
    if (done !== 4'b0010) begin failures++; $display("FAIL bp_done got=%b required=0010", done); end
    tick();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || err !== 1'b0) begin
      failures++; $display("FAIL bp_idle got busy=%b err=%b required=0/0", busy, err);
    end
  endtask

  task automatic test_reset_mid_stream();
    set_job(1, 32'h3000, 32'd10);
    set_job(0, 32'h4000, 32'd1);
    req_val = 4'b0010;
    push_cfg(32'h3000, 32'd10);
    tick();
    req_val = '0;
    tick(); tick(); tick();
    do_beats(3, 1'b0);
    rst = 1'b1;
    tick();
    @(negedge clk);
    checks++;
    if ({req_rdy, done, owner, cfg_valid, cfg_addr, cfg_data, busy, err} !== '0) begin
      failures++;
      $display("FAIL midrst_outputs got rdy=%b done=%b own=%b cv=%b busy=%b err=%b required=all 0",
               req_rdy, done, owner, cfg_valid, busy, err);
    end
    rst = 1'b0;
    tick();
    req_val = 4'b0011;
    @(negedge clk);
    checks++;
    if (req_rdy !== 4'b0001) begin failures++; $display("FAIL midrst_grant got=%b required=0001", req_rdy); end
    push_cfg(32'h4000, 32'd1);
    done_q.push_back(4'b0001);
    tick();
    req_val = '0;
    tick(); tick(); tick();
    do_beats(1, 1'b0);
    @(negedge clk);
    checks++;
    if (done !== 4'b0001) begin failures++; $display("FAIL midrst_done got=%b required=0001", done); end
    tick();
  endtask

  task automatic test_max_len();
    set_job(3, 32'hFFFF_FFFC, 32'hFFFF_FFFF);
    req_val = 4'b1000;
    push_cfg(32'hFFFF_FFFC, 32'hFFFF_FFFF);
    tick();
    req_val = '0;
    tick(); tick(); tick();
    do_beats(3, 1'b0);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || done !== '0 || owner !== 4'b1000) begin
      failures++; $display("FAIL maxlen_running got busy=%b done=%b own=%b required=1/0000/1000", busy, done, owner);
    end
    apply_reset();
  endtask

  task automatic test_stray_beat();
    @(negedge clk);
    checks++;
    if (err !== 1'b0) begin failures++; $display("FAIL stray_pre got=%b required=0", err); end
    strm_valid = 1'b1; strm_ready = 1'b1;
    tick();
    strm_valid = 1'b0; strm_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (err !== 1'b1) begin failures++; $display("FAIL stray_set got=%b required=1", err); end
    set_job(3, 32'h5000, 32'd2);
    req_val = 4'b1000;
    push_cfg(32'h5000, 32'd2);
    done_q.push_back(4'b1000);
    tick();
    req_val = '0;
    tick(); tick(); tick();
    do_beats(2, 1'b0);
    tick();
    @(negedge clk);
    checks++;
    if (err !== 1'b1) begin failures++; $display("FAIL stray_sticky got=%b required=1", err); end
    apply_reset();
    @(negedge clk);
    checks++;
    if (err !== 1'b0) begin failures++; $display("FAIL stray_clear got=%b required=0", err); end
  endtask

  initial begin
    rst = 1'b1; req_val = '0; strm_valid = 1'b0; strm_ready = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_zero_len();
    test_backpressure();
    test_reset_mid_stream();
    test_max_len();
    test_stray_beat();
    tick();
    checks++;
    if (cfg_q.size() != 0 || done_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got cfg=%0d done=%0d required=0/0", cfg_q.size(), done_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
